// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: drives a req/ack memory port,
// packs store lanes, extends load data and flags alignment/encoding faults.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2_data,
    input  logic        ForwardMem,
    input  logic [31:0] wb_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        mem_done,
    output logic [31:0] load_data,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_loadData;
    logic        r_misalign;

    logic        w_inIdle;
    logic        w_inAccess;
    logic        w_isMem;
    logic        w_legal;
    logic        w_aligned;
    logic        w_start;
    logic        w_fault;
    logic [31:0] w_storeSrc;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_loadExt;

    assign w_inIdle   = (r_state == IDLE);
    assign w_inAccess = (r_state == ACCESS);
    assign w_isMem    = MemRead ^ MemWrite;
    assign w_storeSrc = ForwardMem ? wb_data : rs2_data;

    // Loads allow the unsigned byte/half forms; stores only the three sizes.
    always_comb begin
        w_legal = 1'b0;
        if (MemRead) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                default:                                w_legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                default:                w_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~addr[0];
            2'b10:   w_aligned = (addr[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_start = valid & w_isMem & w_legal & w_aligned;
    assign w_fault = valid & ((MemRead & MemWrite) | (w_isMem & ~(w_legal & w_aligned)));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = w_storeSrc;
        case (funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{w_storeSrc[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {addr[1], 1'b0};
                w_wdata = {2{w_storeSrc[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the latched address so rdata only feeds a register.
    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_loadExt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_loadExt = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadExt = {24'b0, w_byte};
            3'b101:  w_loadExt = {16'b0, w_half};
            default: w_loadExt = dmem_rdata;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_nextState = ACCESS;
                    stall       = 1'b1;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Request fields are captured once at start and held until the access ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_be     <= 4'b0000;
        end else if (w_inIdle && w_start) begin
            r_we     <= MemWrite;
            r_funct3 <= funct3;
            r_addr   <= addr;
            r_wdata  <= w_wdata;
            r_be     <= w_be;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loadData <= 32'h0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_inIdle & w_fault;
            if (w_inAccess && dmem_ack && !r_we) begin
                r_loadData <= w_loadExt;
            end
        end
    end

    assign dmem_req     = w_inAccess;
    assign dmem_we      = w_inAccess & r_we;
    assign dmem_addr    = w_inAccess ? {r_addr[31:2], 2'b00} : 32'h0;
    assign dmem_wdata   = w_inAccess ? r_wdata : 32'h0;
    assign dmem_be      = w_inAccess ? r_be : 4'b0000;
    assign mem_done     = (r_state == DONE);
    assign load_data    = r_loadData;
    assign misalign_err = r_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; request and load expectations are
// queued when an access is issued and checked when the DUT presents them.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] rs2_data;
    logic        ForwardMem;
    logic [31:0] wb_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        mem_done;
    logic [31:0] load_data;
    logic        misalign_err;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } reqExp_t;

    reqExp_t     reqQ[$];
    logic [31:0] loadQ[$];
    int          total = 0;
    int          bad   = 0;

    mem_access_unit dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .funct3      (funct3),
        .addr        (addr),
        .rs2_data    (rs2_data),
        .ForwardMem  (ForwardMem),
        .wb_data     (wb_data),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .stall       (stall),
        .mem_done    (mem_done),
        .load_data   (load_data),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] rs2, input logic fwd,
                                 input logic [31:0] wb);
        valid      = v;
        MemRead    = rd;
        MemWrite   = wr;
        funct3     = f3;
        addr       = a;
        rs2_data   = rs2;
        ForwardMem = fwd;
        wb_data    = wb;
    endtask

    // Issues one access, holds ack off for 'waits' ACCESS cycles, then checks DONE.
    task automatic runAccess(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] rs2, input logic fwd,
                             input logic [31:0] wb, input logic [31:0] rdata, input int waits,
                             input logic [3:0] expBe, input logic [31:0] expWdata,
                             input logic [31:0] expLoad);
        reqExp_t e;
        reqExp_t cur;
        logic [31:0] gotLoad;
        @(negedge clk);
        applyStimulus(1'b1, rd, wr, f3, a, rs2, fwd, wb);
        dmem_ack = 1'b0;
        e.we    = wr;
        e.addr  = {a[31:2], 2'b00};
        e.be    = expBe;
        e.wdata = expWdata;
        reqQ.push_back(e);
        if (rd) loadQ.push_back(expLoad);
        #1;
        checkOutput({tag, " stall C0"}, {31'b0, stall}, 32'd1);
        checkOutput({tag, " req C0"}, {31'b0, dmem_req}, 32'd0);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 1'b0, 3'b111, ~a, ~rs2, ~fwd, ~wb);
            dmem_ack   = (i == waits);
            dmem_rdata = (i == waits) ? rdata : 32'h5A5A_5A5A;
            #1;
            cur = reqQ[0];
            checkOutput($sformatf("%s req A%0d", tag, i), {31'b0, dmem_req}, 32'd1);
            checkOutput($sformatf("%s stall A%0d", tag, i), {31'b0, stall}, 32'd1);
            checkOutput($sformatf("%s we A%0d", tag, i), {31'b0, dmem_we}, {31'b0, cur.we});
            checkOutput($sformatf("%s addr A%0d", tag, i), dmem_addr, cur.addr);
            checkOutput($sformatf("%s be A%0d", tag, i), {28'b0, dmem_be}, {28'b0, cur.be});
            if (cur.we) checkOutput($sformatf("%s wdata A%0d", tag, i), dmem_wdata, cur.wdata);
        end
        void'(reqQ.pop_front());
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #1;
        checkOutput({tag, " mem_done"}, {31'b0, mem_done}, 32'd1);
        checkOutput({tag, " stall DONE"}, {31'b0, stall}, 32'd0);
        checkOutput({tag, " req DONE"}, {31'b0, dmem_req}, 32'd0);
        if (rd) begin
            gotLoad = loadQ.pop_front();
            checkOutput({tag, " load_data"}, load_data, gotLoad);
        end
        @(negedge clk);
        #1;
        checkOutput({tag, " mem_done off"}, {31'b0, mem_done}, 32'd0);
    endtask

    task automatic runFault(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a);
        @(negedge clk);
        applyStimulus(1'b1, rd, wr, f3, a, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput({tag, " stall"}, {31'b0, stall}, 32'd0);
        checkOutput({tag, " req"}, {31'b0, dmem_req}, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput({tag, " misalign pulse"}, {31'b0, misalign_err}, 32'd1);
        checkOutput({tag, " req after"}, {31'b0, dmem_req}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput({tag, " misalign clear"}, {31'b0, misalign_err}, 32'd0);
        checkOutput({tag, " no done"}, {31'b0, mem_done}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        $display("[TB] reset phase");
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset stall", {31'b0, stall}, 32'd0);
        checkOutput("reset req", {31'b0, dmem_req}, 32'd0);
        checkOutput("reset done", {31'b0, mem_done}, 32'd0);
        checkOutput("reset load_data", load_data, 32'h0);
        checkOutput("reset misalign", {31'b0, misalign_err}, 32'd0);
        checkOutput("reset be", {28'b0, dmem_be}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("nonmem stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("nonmem misalign", {31'b0, misalign_err}, 32'd0);
        checkOutput("nonmem req", {31'b0, dmem_req}, 32'd0);

        runAccess("LW", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h0, 32'hDEAD_BEEF, 0,
                  4'b1111, 32'h0, 32'hDEAD_BEEF);
        runAccess("LB", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 32'h0, 32'h8012_3456, 0,
                  4'b1000, 32'h0, 32'hFFFF_FF80);
        runAccess("LBU", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b0, 32'h0, 32'h8012_3456, 0,
                  4'b1000, 32'h0, 32'h0000_0080);
        runAccess("SH", 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 1'b1, 32'h0000_1234, 32'h0, 1,
                  4'b1100, 32'h1234_1234, 32'h0);

        runFault("LW misaligned", 1'b1, 1'b0, 3'b010, 32'h101);
        runFault("rd and wr", 1'b1, 1'b1, 3'b000, 32'h100);
        runFault("load f3=011", 1'b1, 1'b0, 3'b011, 32'h100);
        runFault("store f3=100", 1'b0, 1'b1, 3'b100, 32'h100);
        runFault("SH odd", 1'b0, 1'b1, 3'b001, 32'h203);
        checkOutput("load_data held", load_data, 32'h0000_0080);

        runAccess("SW wait4", 1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 1'b0, 32'h1111_1111, 32'h0, 4,
                  4'b1111, 32'hCAFE_F00D, 32'h0);
        runAccess("LH", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1'b0, 32'h0, 32'h8001_1234, 2,
                  4'b1100, 32'h0, 32'hFFFF_8001);
        runAccess("LHU", 1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 1'b0, 32'h0, 32'h8001_9234, 0,
                  4'b0011, 32'h0, 32'h0000_9234);
        runAccess("SB", 1'b0, 1'b1, 3'b000, 32'h001, 32'h0000_00A5, 1'b0, 32'h0, 32'h0, 0,
                  4'b0010, 32'hA5A5_A5A5, 32'h0);
        checkOutput("load_data after SB", load_data, 32'h0000_9234);

        $display("[TB] reset during access");
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'b010, 32'h400, 32'h1122_3344, 1'b0, 32'h0);
        #1;
        checkOutput("rstmid stall C0", {31'b0, stall}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        checkOutput("rstmid req before", {31'b0, dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid req dropped", {31'b0, dmem_req}, 32'd0);
        checkOutput("rstmid stall", {31'b0, stall}, 32'd0);
        checkOutput("rstmid be", {28'b0, dmem_be}, 32'd0);
        checkOutput("rstmid load_data", load_data, 32'h0);
        @(negedge clk);
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h7777_7777;
        #1;
        checkOutput("late ack req", {31'b0, dmem_req}, 32'd0);
        checkOutput("late ack stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        checkOutput("late ack no done", {31'b0, mem_done}, 32'd0);
        checkOutput("late ack load_data", load_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access controller of the 5-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register, consuming the memory-stage forwarding select, and drives a variable-latency data-memory port through a req/ack handshake. It handles byte, half and word alignment, sign and zero extension, and alignment faults. While an access is outstanding it stalls the pipeline.

## Interface
- No parameters. XLEN is fixed at 32.
- `clk` in 1: pipeline clock. One clock domain; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid` in 1: the EX/MEM slot holds a live instruction.
- `MemRead` in 1: the instruction is a load.
- `MemWrite` in 1: the instruction is a store.
- `funct3` in 3: access size and signedness.
- `addr` in 32: effective byte address (ALU result).
- `rs2_data` in 32: store data read from the register file.
- `ForwardMem` in 1: when 1, store data is taken from `wb_data`.
- `wb_data` in 32: MEM/WB write-back value.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: word-aligned address ({addr[31:2],2'b00}).
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_be` out 4: byte enables.
- `dmem_ack` in 1: request accepted and completed this cycle.
- `dmem_rdata` in 32: read word, valid when `dmem_ack`=1.
- `stall` out 1: hold PC, IF/ID, ID/EX and EX/MEM.
- `mem_done` out 1: one-cycle pulse; the access is complete and the pipeline advances.
- `load_data` out 32: extended load result, registered.
- `misalign_err` out 1: one-cycle pulse on an alignment or encoding fault.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE. Reset drives the FSM to IDLE and every output to 0.
- **IDLE, start condition:** `valid` & (`MemRead` ^ `MemWrite`) & legal & aligned. On start:
  - latch addr, funct3 and we;
  - latch store data = `ForwardMem` ? `wb_data` : `rs2_data`;
  - assert `stall`=1 and go to ACCESS.
- **IDLE, fault condition:** `valid` with both `MemRead` and `MemWrite` high, an illegal funct3, or misalignment.
  - Pulse `misalign_err`=1 and keep `stall`=0.
  - Issue no request and stay in IDLE.
- **ACCESS:**
  - `dmem_req`=1, with `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` driven from the latched values and held stable until ack.
  - `stall`=1.
  - On `dmem_ack`: for a load, register the extended `dmem_rdata` into `load_data`; go to DONE.
- **DONE:** `mem_done`=1, `stall`=0 and `dmem_req`=0; return to IDLE next cycle. `load_data` holds until the next load completes.
- **Legal encodings:**
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW;
  - every other encoding is illegal.
- **Alignment rules:** halfword requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
- **Byte enables:**
  - byte: 4'b0001 << addr[1:0];
  - half: 4'b0011 << {addr[1],1'b0};
  - word: 4'b1111;
  - loads drive the same enables.
- **Store write data:** byte = {4{d[7:0]}}, half = {2{d[15:0]}}, word = d.
- **Load extraction:** select the lane by addr[1:0] (byte) or addr[1] (half). Sign-extend for LB/LH; zero-extend for LBU/LHU.
- **Non-memory cycles:** `valid`=0, or neither `MemRead` nor `MemWrite` set, means IDLE with all outputs 0 except the held `load_data`.
- **Inputs outside IDLE:** ignored in ACCESS and DONE. Only the latched copies are used.

## Timing
- Minimum access takes 3 cycles:
  - C0 IDLE start, `stall`=1;
  - C1 ACCESS, `dmem_req`=1 with `dmem_ack`=1;
  - C2 DONE, `mem_done`=1 and `stall`=0.
- Each wait cycle without ack adds one ACCESS cycle with `stall`=1.
- `stall` is combinational: (IDLE & start) | (ACCESS & ~`dmem_ack`) | (ACCESS & `dmem_ack`). It is therefore 1 in every ACCESS cycle.
- `dmem_*`, `mem_done`, `misalign_err` and `load_data` are registered or decoded from state only. There is no combinational path from `dmem_rdata` to outputs.
- Store data is sampled at C0 only; later changes to `wb_data` or `rs2_data` have no effect.
- An asynchronous `rst` during ACCESS drops `dmem_req` immediately and clears all outputs. A late `dmem_ack` after reset is ignored in IDLE.
- Back-to-back memory instructions: the second is seen in IDLE the cycle after DONE. There are no overlapping requests.

## Test plan
- **LW, addr=0x100, dmem_rdata=0xDEADBEEF, ack on first ACCESS cycle:** `dmem_be`=1111, `dmem_we`=0; `stall` high for 2 cycles; `mem_done` on cycle 3; `load_data`=0xDEADBEEF.
- **LB and LBU, addr=0x103, rdata=0x80123456:** LB gives `dmem_be`=1000 and `load_data`=0xFFFFFF80; LBU gives 0x00000080.
- **SH, addr=0x202, rs2_data=0x0000ABCD, ForwardMem=1, wb_data=0x00001234:** `dmem_wdata`=0x12341234, `dmem_be`=1100, `dmem_we`=1. Changing `wb_data` during ACCESS leaves `dmem_wdata` unchanged.
- **LW, addr=0x101:** `misalign_err` pulses for 1 cycle, `dmem_req` never asserts, `stall`=0. Same for `MemRead`=`MemWrite`=1 and for funct3=011 on a load.
- **SW with ack delayed 4 cycles:** request fields stable across all 5 ACCESS cycles; `stall`=1 throughout; `mem_done` one cycle after ack.
- **`rst` asserted mid-ACCESS, then a late ack:** `dmem_req`=0 in the same cycle, FSM in IDLE, no `mem_done` pulse.
